// File: rtl/TauCfg.sv
// rtl/TauCfg.sv - shared work-offset width and grid dimensionality defaults
package TauCfg;
  localparam int WORK_BW = 16;
  localparam int VDIM    = 2;
endpackage

// File: rtl/block_dispatch_ctrl.sv
// rtl/block_dispatch_ctrl.sv - walks a job's block grid, issuing offsets under an in-flight cap
module block_dispatch_ctrl #(
  parameter  int WBW     = TauCfg::WORK_BW,
  parameter  int VDIM    = TauCfg::VDIM,
  parameter  int MAX_OUT = 4,
  localparam int OBW     = $clog2(MAX_OUT + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     job_rdy,
  output logic                     job_ack,
  input  logic [VDIM-1:0][WBW-1:0] i_bgrid_step,
  input  logic [VDIM-1:0][WBW-1:0] i_bgrid_end,
  output logic                     blk_rdy,
  input  logic                     blk_ack,
  output logic [VDIM-1:0][WBW-1:0] o_bofs,
  input  logic                     blkdone_dval,
  output logic                     done_dval,
  output logic                     o_busy,
  output logic [OBW-1:0]           o_outstanding,
  output logic                     o_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [VDIM-1:0][WBW-1:0] step_q, end_q, bofs_q, bofs_d, next_ofs;
  logic [OBW-1:0]           outs_q, outs_d;
  logic                     err_q, err_d;
  logic                     zero_job, last_blk, carry, blk_hs;
  logic [WBW-1:0]           step_eff;
  logic [WBW:0]             sum;

  always_comb begin
    zero_job = 1'b0;
    for (int i = 0; i < VDIM; i++) begin
      if (end_q[i] == '0) zero_job = 1'b1;
    end
  end

  // Odometer increment; the extra sum bit keeps a near-max offset from aliasing below end.
  always_comb begin
    next_ofs = bofs_q;
    carry    = 1'b1;
    step_eff = '0;
    sum      = '0;
    for (int i = VDIM - 1; i >= 0; i--) begin
      if (carry) begin
        step_eff = (step_q[i] == '0) ? WBW'(1) : step_q[i];
        sum      = {1'b0, bofs_q[i]} + {1'b0, step_eff};
        if (sum >= {1'b0, end_q[i]}) begin
          next_ofs[i] = '0;
        end else begin
          next_ofs[i] = sum[WBW-1:0];
          carry       = 1'b0;
        end
      end
    end
    last_blk = carry;
  end

  always_comb begin
    state_d   = state_q;
    bofs_d    = bofs_q;
    outs_d    = outs_q;
    err_d     = err_q;
    job_ack   = 1'b0;
    blk_rdy   = 1'b0;
    done_dval = 1'b0;
    case (state_q)
      IDLE: begin
        job_ack = job_rdy && !i_rst;
        if (job_rdy) begin
          state_d = ISSUE;
          bofs_d  = '0;
        end
      end
      ISSUE: begin
        if (zero_job) begin
          state_d = DRAIN;
        end else begin
          blk_rdy = (outs_q < OBW'(MAX_OUT));
          if (blk_rdy && blk_ack) begin
            bofs_d = next_ofs;
            if (last_blk) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outs_q == '0) begin
          done_dval = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    blk_hs = blk_rdy && blk_ack;
    if (blk_hs && !blkdone_dval) begin
      outs_d = outs_q + 1'b1;
    end else if (!blk_hs && blkdone_dval) begin
      if (outs_q == '0) err_d = 1'b1;
      else              outs_d = outs_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      bofs_q  <= '0;
      outs_q  <= '0;
      err_q   <= 1'b0;
      step_q  <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      bofs_q  <= bofs_d;
      outs_q  <= outs_d;
      err_q   <= err_d;
      if (job_ack) begin
        step_q <= i_bgrid_step;
        end_q  <= i_bgrid_end;
      end
    end
  end

  assign o_bofs        = bofs_q;
  assign o_busy        = (state_q != IDLE);
  assign o_outstanding = outs_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_block_dispatch_ctrl.sv
// tb/tb_block_dispatch_ctrl.sv - randomized bench with a grid-enumeration reference model
module tb_block_dispatch_ctrl;
  localparam int WBW     = 8;
  localparam int VDIM    = 2;
  localparam int MAX_OUT = 2;
  localparam int OBW     = $clog2(MAX_OUT + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_rdy = 1'b0, blk_ack = 1'b0, blkdone = 1'b0;
  logic job_ack, blk_rdy, done_dval, o_busy, o_err;
  logic [VDIM-1:0][WBW-1:0] step_v, end_v, o_bofs;
  logic [OBW-1:0] o_outstanding;

  int d_e0 = 1, d_e1 = 1, d_s0 = 1, d_s1 = 1;
  assign step_v = {WBW'(d_s1), WBW'(d_s0)};
  assign end_v  = {WBW'(d_e1), WBW'(d_e0)};

  always #5 clk = ~clk;

  block_dispatch_ctrl #(.WBW(WBW), .VDIM(VDIM), .MAX_OUT(MAX_OUT)) dut (
    .i_clk(clk), .i_rst(rst), .job_rdy(job_rdy), .job_ack(job_ack),
    .i_bgrid_step(step_v), .i_bgrid_end(end_v),
    .blk_rdy(blk_rdy), .blk_ack(blk_ack), .o_bofs(o_bofs),
    .blkdone_dval(blkdone), .done_dval(done_dval), .o_busy(o_busy),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a job is the list of grid points, issued in order, plus an in-flight count.
  bit m_busy = 0, m_drain = 0, m_err = 0;
  int m_outs = 0, m_idx = 0;
  int qa[$], qb[$];

  function automatic void build_list();
    int s0, s1;
    qa.delete();
    qb.delete();
    if (d_e0 == 0 || d_e1 == 0) return;
    s0 = (d_s0 == 0) ? 1 : d_s0;
    s1 = (d_s1 == 0) ? 1 : d_s1;
    for (int a = 0; a < d_e0; a += s0)
      for (int b = 0; b < d_e1; b += s1) begin
        qa.push_back(a);
        qb.push_back(b);
      end
  endfunction

  task automatic set_job(input int e0, input int e1, input int s0, input int s1);
    d_e0 = e0; d_e1 = e1; d_s0 = s0; d_s1 = s1;
  endtask

  task automatic cyc(input logic jr, input logic ba, input logic bd);
    bit e_ack, e_rdy, e_done, hs;
    int e_bofs;
    @(negedge clk);
    job_rdy = jr; blk_ack = ba; blkdone = bd;
    #1;
    e_ack  = !m_busy && jr;
    e_rdy  = m_busy && !m_drain && (m_idx < qa.size()) && (m_outs < MAX_OUT);
    e_done = m_busy && m_drain && (m_outs == 0);
    e_bofs = 0;
    if (m_busy && !m_drain && m_idx < qa.size()) e_bofs = (qb[m_idx] << 8) | qa[m_idx];
    chk("job_ack", 32'(job_ack), 32'(e_ack));
    chk("blk_rdy", 32'(blk_rdy), 32'(e_rdy));
    chk("done_dval", 32'(done_dval), 32'(e_done));
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("outstanding", 32'(o_outstanding), m_outs);
    chk("err", 32'(o_err), 32'(m_err));
    chk("bofs", 32'(o_bofs), e_bofs);
    hs = e_rdy && ba;
    if (!m_busy) begin
      if (jr) begin
        m_busy = 1; m_drain = 0; m_idx = 0;
        build_list();
      end
    end else if (!m_drain) begin
      if (hs) m_idx++;
      if (m_idx == qa.size()) m_drain = 1;
    end else if (e_done) begin
      m_busy = 0;
    end
    if (hs && !bd) m_outs++;
    else if (!hs && bd) begin
      if (m_outs == 0) m_err = 1;
      else m_outs--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; job_rdy = 1; blk_ack = 1; blkdone = 1;
    @(negedge clk);
    #1;
    chk("rst_job_ack", 32'(job_ack), 0);
    chk("rst_blk_rdy", 32'(blk_rdy), 0);
    chk("rst_done", 32'(done_dval), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_outs", 32'(o_outstanding), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_bofs", 32'(o_bofs), 0);
    rst = 0; job_rdy = 0; blk_ack = 0; blkdone = 0;
    m_busy = 0; m_drain = 0; m_err = 0; m_outs = 0; m_idx = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic run_job(input int ack_pct);
    logic ba, bd;
    for (int k = 0; k < 4000 && m_busy; k++) begin
      ba = ($urandom_range(99) < ack_pct);
      bd = (m_outs > 0) ? ($urandom_range(2) == 0) : ($urandom_range(49) == 0);
      cyc(1'b0, ba, bd);
    end
    if (m_busy) begin
      chk("job_timeout", 1, 0);
      do_reset();
    end
  endtask

  initial begin
    do_reset();

    // stray retire while idle is an error that only reset clears
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    do_reset();

    set_job(4, 6, 2, 3);
    cyc(1, 0, 0);
    run_job(100);

    // zero-block job: done two cycles after the accept
    set_job(0, 5, 1, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);

    // in-flight cap, then one retire reopens issue; then ack+retire together
    set_job(1, 8, 1, 1);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    run_job(100);

    // near-max offsets must wrap rather than alias
    set_job(1, 250, 1, 200);
    cyc(1, 0, 0);
    run_job(100);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    do_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    repeat (40) begin
      set_job($urandom_range(12), $urandom_range(12), $urandom_range(5), $urandom_range(5));
      cyc(1, 0, 0);
      if ($urandom_range(4) == 0) begin
        repeat ($urandom_range(10, 1)) cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        do_reset();
        cyc(0, 0, 0);
      end else begin
        run_job($urandom_range(100, 30));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/block_dispatch_ctrl.md
BLOCK_DISPATCH_CTRL -- requirements
Module: block_dispatch_ctrl

Interface
REQ-001 Parameters SHALL be: WBW, default TauCfg::WORK_BW, offset width; VDIM, default TauCfg::VDIM, grid dimensions; MAX_OUT, default 4, maximum in-flight blocks (>=1); OBW = $clog2(MAX_OUT+1).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1: sole clock.
- i_rst, in, 1: synchronous, active-high reset.
- job_rdy, in, 1: job descriptor valid.
- job_ack, out, 1: job accepted.
- i_bgrid_step, in, WBW x VDIM: per-dimension block stride.
- i_bgrid_end, in, WBW x VDIM: per-dimension exclusive end.
- blk_rdy, out, 1: block offset valid toward the block looper src.
- blk_ack, in, 1: looper accepts the block.
- o_bofs, out, WBW x VDIM: current block offset.
- blkdone_dval, in, 1: one-cycle pulse, one block fully retired.
- done_dval, out, 1: one-cycle pulse, job complete.
- o_busy, out, 1: state != IDLE.
- o_outstanding, out, OBW: issued-but-not-retired block count.
- o_err, out, 1: sticky protocol error.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, DRAIN, encoded in registers.
REQ-004 A handshake SHALL complete in any cycle where rdy && ack; a sender holds rdy and data stable until it completes.
REQ-005 In IDLE, job_ack SHALL equal job_rdy (combinational); on job handshake, step/end are latched, o_bofs cleared to 0, next state ISSUE.
REQ-006 job_ack SHALL be 0 outside IDLE.
REQ-007 If any latched end[i]==0, the job SHALL contain zero blocks: next state DRAIN with no blk_rdy ever asserted.
REQ-008 blk_rdy SHALL be 1 iff state==ISSUE && o_outstanding < MAX_OUT.
REQ-009 Iteration order SHALL be lexicographic with dimension VDIM-1 fastest: on each blk handshake, dim VDIM-1 += step; if the sum >= end, that dim resets to 0 and carries to the next lower index.
REQ-010 Increment SHALL be computed at WBW+1 bits, so sums past 2^WBW-1 wrap the dimension and never alias.
REQ-011 A blk handshake SHALL be the last block when every dimension would wrap; the next state is then DRAIN and o_bofs returns to all-zero.
REQ-012 step[i]==0 with end[i]>0 SHALL be treated as step 1.
REQ-013 o_outstanding SHALL increment on a blk handshake, decrement on blkdone_dval, and stay unchanged when both occur in the same cycle.
REQ-014 blkdone_dval while o_outstanding==0 and no same-cycle handshake SHALL leave the count at 0 and set o_err.
REQ-015 In DRAIN, when o_outstanding==0 (registered value), done_dval SHALL pulse for exactly 1 cycle and the next state is IDLE.
REQ-016 Latency SHALL be: job handshake -> first blk_rdy in 1 cycle; last blkdone -> done_dval in 1 cycle.
REQ-017 A new job SHALL be accepted in the cycle after done_dval at the earliest.

Reset
REQ-018 While i_rst is high at a clock edge, the block SHALL enter IDLE with o_bofs=0, o_outstanding=0, o_err=0, and blk_rdy, job_ack, done_dval, o_busy all 0.
REQ-019 Reset mid-job SHALL abandon the job silently, with no done_dval; blkdone_dval pulses after reset set o_err.
REQ-020 o_err SHALL clear only on reset.

Verification
REQ-021 Setup VDIM=2, MAX_OUT=4, end={4,6}, step={2,3}, blk_ack always 1, blkdone 3 cycles after each issue -> o_bofs sequence {0,0},{0,3},{2,0},{2,3}; done_dval 1 cycle after the 4th blkdone.
REQ-022 Setup MAX_OUT=2, end={1,8}, step={1,1}, blkdone never -> exactly 2 handshakes, then blk_rdy=0 and o_outstanding=2; one blkdone pulse re-enables blk_rdy the next cycle.
REQ-023 end={0,5} -> job_ack, then done_dval 2 cycles later, zero blk handshakes.
REQ-024 blk_ack and blkdone_dval in the same cycle with o_outstanding=1 -> count stays 1; stray blkdone in IDLE -> o_err=1, count stays 0.
REQ-025 WBW=8, end={1,250}, step={1,200} -> blocks {0,0},{0,200} only, with no wrap aliasing; reset asserted after the first block -> IDLE, no done_dval.
